// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and FSM state type.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

endpackage

// File: rtl/full_adder_gate.sv
// Single-bit combinational full adder cell.
module full_adder_gate (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder cell, LSB first, registered carry loop.
// Result is valid with a one-cycle done pulse WIDTH+1 cycles after the accepted start.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned         CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]     CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Bit 0 of the partial-sum shift register is never read, so only the upper bits are kept.
  logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] shifted_sum;

  full_adder_gate u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign shifted_sum = {fa_sum, sum_sr_q};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d   = a_in;
          b_sr_d   = b_in;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        sum_sr_d = shifted_sum[WIDTH-1:1];
        carry_d  = fa_cout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          sum_d   = shifted_sum;
          cout_d  = fa_cout;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard of a+b+cin results popped on each done pulse.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } result_t;

  result_t      sb_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           done_cnt = 0;
  logic [W-1:0] held_sum = '0;
  logic         held_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge; the main thread drives just after the rising edge.
  always @(negedge clk) begin
    check_eq("busy_done_excl", {63'd0, busy & done}, 64'd0);
    if (rst) begin
      held_sum  = '0;
      held_cout = 1'b0;
    end else if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        result_t r;
        r = sb_q.pop_front();
        check_eq("sb_sum", {56'd0, sum}, {56'd0, r.sum});
        check_eq("sb_cout", {63'd0, cout}, {63'd0, r.cout});
      end
      held_sum  = sum;
      held_cout = cout;
    end else begin
      check_eq("hold_sum", {56'd0, sum}, {56'd0, held_sum});
      check_eq("hold_cout", {63'd0, cout}, {63'd0, held_cout});
    end
  end

  // Drives one operation; glitch_at>0 pulses start with other operands that many cycles in.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int glitch_at);
    logic [W:0] full;
    int         lat;
    int         busy_cycles;
    int         d0;
    bit         got;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    sb_q.push_back('{sum: full[W-1:0], cout: full[W]});
    a_in = a; b_in = b; cin = c; start = 1'b1;
    d0 = done_cnt;
    got = 1'b0; lat = 0; busy_cycles = 0;
    for (int i = 1; i <= int'(W) + 6; i++) begin
      tick();
      start = 1'b0;
      if (glitch_at > 0 && i == glitch_at) begin
        a_in = ~a; b_in = a ^ b; cin = ~c; start = 1'b1;
      end
      if (busy) busy_cycles++;
      if (done) begin
        got = 1'b1; lat = i; break;
      end
    end
    start = 1'b0;
    if (!got) begin
      check_eq("done_timeout", 64'd0, 64'd1);
    end else begin
      check_eq("latency", 64'(lat), 64'(W + 1));
      check_eq("busy_cycles", 64'(busy_cycles), 64'(W));
    end
    tick();
    if (glitch_at > 0) begin
      for (int i = 0; i < int'(W) + 4; i++) tick();
      check_eq("single_done", 64'(done_cnt - d0), 64'd1);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    int           d0;

    // Reset state
    #2;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_sum", {56'd0, sum}, 64'd0);
    check_eq("rst_cout", {63'd0, cout}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("idle_busy", {63'd0, busy}, 64'd0);

    do_op(8'h00, 8'h00, 1'b0, 0);
    check_eq("zero_sum", {56'd0, sum}, 64'h00);
    check_eq("zero_cout", {63'd0, cout}, 64'd0);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    check_eq("ff01_sum", {56'd0, sum}, 64'h00);
    check_eq("ff01_cout", {63'd0, cout}, 64'd1);
    do_op(8'h7F, 8'h01, 1'b0, 0);
    check_eq("7f01_sum", {56'd0, sum}, 64'h80);
    check_eq("7f01_cout", {63'd0, cout}, 64'd0);
    do_op(8'hA5, 8'h5A, 1'b1, 0);
    check_eq("a55a_sum", {56'd0, sum}, 64'h00);
    check_eq("a55a_cout", {63'd0, cout}, 64'd1);

    // Start pulsed mid-RUN must be ignored
    do_op(8'h3C, 8'h42, 1'b0, 3);
    check_eq("glitch_sum", {56'd0, sum}, 64'h7E);

    // Reset during cycle 4 of RUN aborts with no done pulse
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    check_eq("abort_sum", {56'd0, sum}, 64'd0);
    check_eq("abort_cout", {63'd0, cout}, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < int'(W) + 4; i++) tick();
    check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
    do_op(8'h12, 8'h34, 1'b1, 0);
    check_eq("post_rst_sum", {56'd0, sum}, 64'h47);

    // Random back-to-back traffic
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      do_op(ra, rb, rc, 0);
    end

    tick(); tick();
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around one instance of the existing single-bit `full_adder_gate`. It accepts two operands and a carry-in with a start pulse, feeds the full adder one bit per clock (LSB first) through a registered carry loop, and returns a registered sum and carry-out with a one-cycle done pulse. It is the sequential stage that drives the full adder cell, trading WIDTH+1 cycles of latency for a single adder cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- a_in  in  WIDTH  operand A; captured on the accepted start edge.
- b_in  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in; captured on the accepted start edge.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  single-cycle completion pulse (DONE).
- sum  out  WIDTH  registered result, i.e. (a_in + b_in + cin) mod 2^WIDTH.
- cout  out  1  registered carry-out of the MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - a_sr<=a_in, b_sr<=b_in, carry<=cin, cnt<=0, sum_sr<=0.
  - Next state RUN.
- IDLE, start=0: hold state.
- RUN, each cycle:
  - Full adder inputs are a_sr[0], b_sr[0], carry.
  - sum_sr<={fa_sum, sum_sr[WIDTH-1:1]}; carry<=fa_cout.
  - a_sr and b_sr shift right with zero fill; cnt<=cnt+1.
- RUN exit: when cnt==WIDTH-1, the final bit is processed that cycle.
  - sum<={fa_sum, sum_sr[WIDTH-1:1]}, cout<=fa_cout.
  - Next state DONE.
- DONE: done=1 for exactly one cycle, then unconditionally back to IDLE.
- start in RUN or DONE is ignored and not queued. Operands changing after capture have no effect.
- sum and cout change only on the RUN→DONE edge. They hold their value through IDLE until the next completion.
- cnt width is $clog2(WIDTH). Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only through cout.
- Reset, at any time including mid-RUN:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - All shift registers, carry, and cnt cleared.
  - An aborted operation produces no done pulse.

## Timing
- start accepted at edge k.
- busy=1 during cycles k+1 .. k+WIDTH (WIDTH cycles).
- done=1 during cycle k+WIDTH+1. sum and cout are valid in that cycle and held afterwards.
- Latency from start edge to done is WIDTH+1 cycles.
- The earliest next accepted start is the edge ending the done cycle's successor, i.e. back-to-back throughput is one result per WIDTH+2 cycles.
- busy and done are never high together.
- busy and done are decoded from registered state only; no combinational path from inputs to outputs.
- The full adder path is combinational within one cycle: register → full_adder_gate → register.

## Structure
- Shared package serial_adder_pkg holds the state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
- Exactly one sub-module: full_adder_gate, ports a, b, cin, sum, cout. It is instantiated once, connected to a_sr[0], b_sr[0], carry, fa_sum, fa_cout.
- The rest is a single always block for state and datapath registers (async rst) plus continuous assigns for busy and done.

## Test plan
- WIDTH=8, a=8'h00, b=8'h00, cin=0 → busy high 8 cycles, done at start+9, sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1; a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0.
- a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1. Check full carry ripple through every bit.
- Pulse start again mid-RUN with different operands → ignored; the result matches the first operands and exactly one done pulse is seen.
- Assert rst at cycle 4 of RUN → busy, done, sum, cout go to 0 immediately. No done pulse; the next start completes correctly.
- Random back-to-back sequence of 200 operations (start reasserted the cycle after each done) → every sum/cout matches the reference a+b+cin, and sum is stable between done pulses.
